// File: rtl/fc_mul_rr_arbiter_if.sv
// Requester, response and multiplier-side signals of the shared FC-layer multiplier arbiter.
// The arbiter uses the slave modport; requesters and the multiplier use the master modport.
interface fc_mul_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    // Both request and response sides use valid/ready handshakes.
    // A transfer happens on a rising clock edge where valid and ready are both high.
    // On the request side, ready depends combinationally on valid.
    // A requester may drop valid at any time before a transfer.
    // Operands only need to be stable in the cycle in which the request is accepted.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [2*DW-1:0]    rsp_data;
    logic               mul_ce;
    logic [DW-1:0]      mul_din0;
    logic [DW-1:0]      mul_din1;
    logic [2*DW-1:0]    mul_dout;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_dout,
        output req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_dout,
        input  req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1
    );
endinterface

// File: rtl/fc_mul_rr_arbiter.sv
// Round-robin arbiter that shares one pipelined multiplier between FC MAC lanes.
// A tag pipe routes each product back to the lane that issued it; backpressure freezes the pipe.
module fc_mul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int MUL_LAT = 1,
    parameter int TW      = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    fc_mul_rr_arbiter_if.slave bus,
    output logic               busy,
    output logic [2:0]         inflight
);
    logic [MUL_LAT-1:0]         vld_q, vld_d;
    logic [MUL_LAT-1:0][TW-1:0] tag_q, tag_d;
    logic [TW-1:0]              rr_q, rr_d;
    logic [DW-1:0]              din0_q, din0_d;
    logic [DW-1:0]              din1_q, din1_d;

    logic          last_vld;
    logic [TW-1:0] last_tag;
    logic          stall;
    logic          ce;
    logic          any_req;
    logic          issue;
    logic [TW-1:0] grant_idx;

    assign last_vld = vld_q[MUL_LAT-1];
    assign last_tag = tag_q[MUL_LAT-1];
    assign stall    = last_vld && !bus.rsp_ready[last_tag];
    assign ce       = !stall;
    // Gating with reset_n keeps req_ready low during reset even if lanes are requesting.
    assign issue    = reset_n && any_req && ce;

    always_comb begin
        int idx;
        idx       = 0;
        any_req   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && bus.req_valid[idx]) begin
                any_req   = 1'b1;
                grant_idx = TW'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (issue) bus.req_ready[grant_idx] = 1'b1;
        if (last_vld) bus.rsp_valid[last_tag] = 1'b1;
    end

    // Operands hold their last issued value on idle cycles to avoid toggling the multiplier.
    always_comb begin
        din0_d = din0_q;
        din1_d = din1_q;
        rr_d   = rr_q;
        if (issue) begin
            din0_d = bus.req_a[int'(grant_idx)*DW +: DW];
            din1_d = bus.req_b[int'(grant_idx)*DW +: DW];
            rr_d   = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (ce) begin
            for (int s = MUL_LAT-1; s > 0; s--) begin
                vld_d[s] = vld_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
            vld_d[0] = issue;
            tag_d[0] = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            tag_q  <= '0;
            rr_q   <= '0;
            din0_q <= '0;
            din1_q <= '0;
        end else begin
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            rr_q   <= rr_d;
            din0_q <= din0_d;
            din1_q <= din1_d;
        end
    end

    assign bus.rsp_data = bus.mul_dout;
    assign bus.mul_ce   = ce;
    assign bus.mul_din0 = din0_d;
    assign bus.mul_din1 = din1_d;
    assign inflight     = 3'($countones(vld_q));
    assign busy         = |vld_q;
endmodule

// File: tb/tb_fc_mul_rr_arbiter.sv
// Bench for fc_mul_rr_arbiter: two instances (MUL_LAT 1 and 3) share one stimulus stream,
// each checked every cycle against a queue-based model of the in-flight operations.
module tb_fc_mul_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;

    typedef struct {
        int              lane;
        logic [2*DW-1:0] prod;
        int              adv;
    } op_t;

    logic               clk;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;

    logic [NREQ-1:0] rdy_o  [2];
    logic [NREQ-1:0] rspv_o [2];
    logic [2*DW-1:0] rspd_o [2];
    logic            ce_o   [2];
    logic            busy_o [2];
    logic [2:0]      infl_o [2];

    int n_tests;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs, multiplier models, reference models ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
        localparam int LAT = (gi == 0) ? 1 : 3;

        fc_mul_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
        logic            busy;
        logic [2:0]      inflight;
        logic [2*DW-1:0] mstage [LAT];
        op_t             q [$];
        int              m_rr;
        logic [DW-1:0]   m_d0;
        logic [DW-1:0]   m_d1;

        assign bus.req_valid = req_valid;
        assign bus.req_a     = req_a;
        assign bus.req_b     = req_b;
        assign bus.rsp_ready = rsp_ready;
        assign bus.mul_dout  = mstage[LAT-1];

        assign rdy_o[gi]  = bus.req_ready;
        assign rspv_o[gi] = bus.rsp_valid;
        assign rspd_o[gi] = bus.rsp_data;
        assign ce_o[gi]   = bus.mul_ce;
        assign busy_o[gi] = busy;
        assign infl_o[gi] = inflight;

        fc_mul_rr_arbiter #(.NREQ(NREQ), .DW(DW), .MUL_LAT(LAT), .TW(2)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .bus      (bus),
            .busy     (busy),
            .inflight (inflight)
        );

        // External pipelined multiplier: not reset, advances only with mul_ce.
        always @(posedge clk) begin
            if (bus.mul_ce) begin
                mstage[0] <= 64'(bus.mul_din0) * 64'(bus.mul_din1);
                for (int s = 1; s < LAT; s++) mstage[s] <= mstage[s-1];
            end
        end

        // Scoreboard: each op needs LAT enabled cycles, then waits at the head until accepted.
        always @(negedge clk) begin : p_cmp
            logic [NREQ-1:0] e_rdy;
            logic [NREQ-1:0] e_rspv;
            logic            e_ce;
            logic            head_out;
            logic            found;
            logic            issue;
            int              g;
            int              l;
            logic [DW-1:0]   d0;
            logic [DW-1:0]   d1;
            op_t             nop;
            if (!reset_n) begin
                q.delete();
                m_rr = 0;
                m_d0 = '0;
                m_d1 = '0;
                check($sformatf("L%0d rst req_ready", LAT), 64'(bus.req_ready), 64'h0);
                check($sformatf("L%0d rst rsp_valid", LAT), 64'(bus.rsp_valid), 64'h0);
                check($sformatf("L%0d rst mul_ce", LAT), 64'(bus.mul_ce), 64'h1);
                check($sformatf("L%0d rst mul_din0", LAT), 64'(bus.mul_din0), 64'h0);
                check($sformatf("L%0d rst mul_din1", LAT), 64'(bus.mul_din1), 64'h0);
                check($sformatf("L%0d rst busy", LAT), 64'(busy), 64'h0);
                check($sformatf("L%0d rst inflight", LAT), 64'(inflight), 64'h0);
            end else begin
                head_out = (q.size() > 0) && (q[0].adv == LAT);
                e_rspv   = '0;
                e_ce     = 1'b1;
                if (head_out) begin
                    e_rspv[q[0].lane] = 1'b1;
                    e_ce = rsp_ready[q[0].lane];
                end
                found = 1'b0;
                g     = 0;
                for (int k = 0; k < NREQ; k++) begin
                    l = (m_rr + k) % NREQ;
                    if (!found && req_valid[l]) begin
                        found = 1'b1;
                        g     = l;
                    end
                end
                issue = found && e_ce;
                e_rdy = '0;
                d0    = m_d0;
                d1    = m_d1;
                if (issue) begin
                    e_rdy[g] = 1'b1;
                    d0 = req_a[g*DW +: DW];
                    d1 = req_b[g*DW +: DW];
                end
                check($sformatf("L%0d req_ready", LAT), 64'(bus.req_ready), 64'(e_rdy));
                check($sformatf("L%0d rsp_valid", LAT), 64'(bus.rsp_valid), 64'(e_rspv));
                check($sformatf("L%0d mul_ce", LAT), 64'(bus.mul_ce), 64'(e_ce));
                check($sformatf("L%0d mul_din0", LAT), 64'(bus.mul_din0), 64'(d0));
                check($sformatf("L%0d mul_din1", LAT), 64'(bus.mul_din1), 64'(d1));
                check($sformatf("L%0d inflight", LAT), 64'(inflight), 64'(q.size()));
                check($sformatf("L%0d busy", LAT), 64'(busy), 64'(q.size() != 0));
                if (head_out) check($sformatf("L%0d rsp_data", LAT), bus.rsp_data, q[0].prod);
                if (e_ce) begin
                    if (head_out) void'(q.pop_front());
                    foreach (q[i]) q[i].adv++;
                    if (issue) begin
                        nop.lane = g;
                        nop.prod = 64'(d0) * 64'(d1);
                        nop.adv  = 1;
                        q.push_back(nop);
                        m_rr = (g + 1) % NREQ;
                        m_d0 = d0;
                        m_d1 = d1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    function automatic logic [DW-1:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Single op on lane 2 with a carry into the upper product word.
        set_lane(2, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b0100;
        mid();
        check("t1 ready c0", 64'(rdy_o[0]), 64'h4);
        check("t1 inflight c0", 64'(infl_o[0]), 64'h0);
        tick();
        req_valid = '0;
        mid();
        check("t1 rsp_valid c1", 64'(rspv_o[0]), 64'h4);
        check("t1 rsp_data c1", rspd_o[0], 64'h1_FFFF_FFFE);
        check("t1 inflight c1", 64'(infl_o[0]), 64'h1);
        tick();
        idle(4);

        // Five back-to-back ops from lane 3 through the 3-stage multiplier.
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 5) ? 4'b1000 : 4'b0000;
            set_lane(3, 32'(c + 1), 32'd3);
            mid();
            case (c)
                0: check("t4 ready c0", 64'(rdy_o[1]), 64'h8);
                2: begin
                    check("t4 rsp_valid c2", 64'(rspv_o[1]), 64'h0);
                    check("t4 inflight c2", 64'(infl_o[1]), 64'h2);
                end
                3: begin
                    check("t4 inflight c3", 64'(infl_o[1]), 64'h3);
                    check("t4 rsp_valid c3", 64'(rspv_o[1]), 64'h8);
                    check("t4 rsp_data c3", rspd_o[1], 64'd3);
                end
                4: check("t4 rsp_data c4", rspd_o[1], 64'd6);
                7: begin
                    check("t4 rsp_data c7", rspd_o[1], 64'd15);
                    check("t4 busy c7", 64'(busy_o[1]), 64'h1);
                end
                8: begin
                    check("t4 busy c8", 64'(busy_o[1]), 64'h0);
                    check("t4 inflight c8", 64'(infl_o[1]), 64'h0);
                end
                default: ;
            endcase
            tick();
        end

        // Backpressure on lane 1 while lane 0 keeps requesting.
        set_lane(1, 32'd5, 32'd7);
        set_lane(0, 32'd9, 32'd9);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c == 0) ? 4'b0010 : (c < 5) ? 4'b0001 : 4'b0000;
            rsp_ready = (c >= 1 && c <= 3) ? 4'b1101 : 4'b1111;
            mid();
            case (c)
                0: check("t3 ready c0", 64'(rdy_o[0]), 64'h2);
                1, 3: begin
                    check("t3 mul_ce stall", 64'(ce_o[0]), 64'h0);
                    check("t3 ready stall", 64'(rdy_o[0]), 64'h0);
                    check("t3 rsp_valid stall", 64'(rspv_o[0]), 64'h2);
                    check("t3 rsp_data stall", rspd_o[0], 64'd35);
                end
                4: begin
                    check("t3 mul_ce release", 64'(ce_o[0]), 64'h1);
                    check("t3 ready release", 64'(rdy_o[0]), 64'h1);
                end
                5: check("t3 rsp_data lane0", rspd_o[0], 64'd81);
                default: ;
            endcase
            tick();
        end
        idle(6);

        // Sparse requests with pointer wrap from lane 3 to lane 0, bubbles between.
        set_lane(0, 32'd6, 32'd7);
        set_lane(2, 32'd3, 32'd4);
        set_lane(3, 32'd2, 32'd5);
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b0100 : (c == 2 || c == 3) ? 4'b1001 : 4'b0000;
            mid();
            case (c)
                0: check("t5 ready c0", 64'(rdy_o[0]), 64'h4);
                1: check("t5 rsp_data c1", rspd_o[0], 64'd12);
                2: begin
                    check("t5 ready wrap", 64'(rdy_o[0]), 64'h8);
                    check("t5 bubble rsp_valid", 64'(rspv_o[0]), 64'h0);
                end
                3: begin
                    check("t5 ready after wrap", 64'(rdy_o[0]), 64'h1);
                    check("t5 rsp_data c3", rspd_o[0], 64'd10);
                end
                4: check("t5 rsp_data c4", rspd_o[0], 64'd42);
                default: ;
            endcase
            tick();
        end
        idle(6);

        // Reset with ops in flight in the 3-stage instance.
        for (int c = 0; c < 4; c++) begin
            req_valid = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0100 : (c == 3) ? 4'b1111 : 4'b0000;
            reset_n   = (c != 2);
            mid();
            case (c)
                1: check("t6 inflight pre", 64'(infl_o[1]), 64'h1);
                2: begin
                    check("t6 inflight rst", 64'(infl_o[1]), 64'h0);
                    check("t6 rsp_valid rst", 64'(rspv_o[1]), 64'h0);
                end
                3: begin
                    check("t6 ptr reset L3", 64'(rdy_o[1]), 64'h1);
                    check("t6 ptr reset L1", 64'(rdy_o[0]), 64'h1);
                end
                default: ;
            endcase
            tick();
        end
        idle(6);

        // Randomized traffic with random backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 60);
                rsp_ready[i] = ($urandom_range(0, 99) < 75);
                set_lane(i, pick_op(), pick_op());
            end
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc_mul_rr_arbiter.md
Name: fc_mul_rr_arbiter

Overview:
Shares one pipelined unsigned 32x32->64 multiplier between NREQ requesters in the FC layer datapath.
Requesters are FC neuron/MAC lanes.
- Arbitrates round-robin and drives the multiplier operands and clock-enable.
- Tracks in-flight tags through the multiplier pipeline.
- Returns each 64-bit product to the requester that issued it, with per-requester backpressure that freezes the multiplier pipeline.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, operand width; product width is 2*DW
MUL_LAT, 1, multiplier register stages from operand capture to valid dout (1..4)
TW, 2, tag width, equal to ceil(log2(NREQ))

Ports:
clk  in  1  clock; all flops on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*DW  operand A per requester; lane i is bits [i*DW +: DW]
req_b  in  NREQ*DW  operand B per requester
rsp_valid  out  NREQ  product valid, one-hot or zero
rsp_ready  in  NREQ  per-requester response accept
rsp_data  out  2*DW  product, shared by all lanes
mul_ce  out  1  multiplier clock-enable
mul_din0  out  DW  multiplier operand 0
mul_din1  out  DW  multiplier operand 1
mul_dout  in  2*DW  multiplier product, MUL_LAT cycles after capture
busy  out  1  at least one operation in flight
inflight  out  3  count of in-flight operations, 0..MUL_LAT

Behaviour:
- Reset (reset_n low, async):
  - tag-pipe valid bits clear; rr_ptr = 0.
  - Outputs: req_ready=0, rsp_valid=0, busy=0, inflight=0.
  - mul_ce=1 (no stall while empty); mul_din0/mul_din1=0.
  - Multiplier contents are not reset and are ignored via tag valid bits.
- Tag pipe:
  - MUL_LAT stages of {valid, tag[TW-1:0]}.
  - Advances only when mul_ce=1, in lockstep with the multiplier registers.
  - Stage 0 loads {issue, grant_idx}.
- Stall:
  - stall = last.valid and not rsp_ready[last.tag].
  - mul_ce = not stall. Purely combinational; no pipeline bubbles are inserted.
- Response:
  - rsp_valid[i] = last.valid and (last.tag == i).
  - rsp_data = mul_dout.
  - rsp_data and rsp_valid hold stable while stalled.
- Arbitration:
  - Combinational scan of req_valid, starting at rr_ptr, in increasing index order with wrap.
  - First asserted lane is grant_idx.
  - issue = any req_valid and mul_ce.
  - req_ready[grant_idx] = issue; all other lanes 0. req_ready depends on req_valid.
- Operands:
  - mul_din0/mul_din1 = req_a/req_b of grant_idx when issue, else hold the previous value. Holding avoids toggling.
  - A non-issue cycle with mul_ce=1 inserts a bubble: stage-0 valid=0.
- Pointer update:
  - On issue, rr_ptr <= (grant_idx+1) mod NREQ.
  - Otherwise rr_ptr holds.
- Latency: accept at edge k gives rsp_valid from cycle k+MUL_LAT, plus any stall cycles.
  - Throughput is 1 op/cycle when unstalled.
- Ordering: responses return in issue order. No reordering between lanes.
- inflight/busy: inflight = popcount of tag-pipe valid bits; busy = (inflight != 0).
- Simultaneous response and issue:
  - When last.valid, rsp_ready is high and a new request is present in the same cycle, both occur.
  - The pipe shifts and the new op enters stage 0.
- Requester semantics:
  - A requester may drop req_valid without a handshake.
  - Operands must be stable only in the accept cycle.
- Reset mid-operation: all in-flight ops are discarded. No rsp_valid is produced for them after reset_n rises.

Test Plan:
1. Single op, NREQ=4, MUL_LAT=1: lane 2 requests a=0xFFFFFFFF, b=2 at cycle 0 -> req_ready=4'b0100 in cycle 0; cycle 1 rsp_valid=4'b0100, rsp_data=0x1_FFFFFFFE.
2. Round-robin: all 4 lanes hold req_valid with a=i+1, b=10 -> grants 0,1,2,3,0 on consecutive cycles; rsp_data 10,20,30,40 in order, each on the matching lane.
3. Backpressure: lane 1 response pending with rsp_ready[1]=0 for 3 cycles, lane 0 requesting -> mul_ce=0 and req_ready=0 for 3 cycles; rsp_data stable. After release, lane 0 is issued the same cycle.
4. MUL_LAT=3 back-to-back: 5 ops from lane 3 -> inflight reaches 3; first rsp at cycle 3, then one per cycle; busy falls one cycle after the last response.
5. Sparse/wrap: rr_ptr=3, only lane 0 and lane 3 valid -> lane 3 granted first, then lane 0. Bubble cycles produce no rsp_valid.
6. Reset mid-flight: MUL_LAT=2 with 2 ops in flight, assert reset_n low for 1 cycle -> rsp_valid=0, inflight=0, rr_ptr=0; no stale response afterward.
